// File: rtl/cur_fetch.sv
// Current-frame fetcher: walks the frame in 8x8 blocks, prefetching 32-bit words into a 4-entry FIFO.
// Optional macro CUR_FETCH_STALL_CNT_EN adds a saturating consumer-stall counter output.
module cur_fetch #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              need_cur,
  output logic [31:0]       cur_word,
  output logic              cur_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              frame_done
`ifdef CUR_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int BX_N    = FRAME_W / 8;
  localparam int BY_N    = FRAME_H / 8;
  localparam int BX_W    = (BX_N > 1) ? $clog2(BX_N) : 1;
  localparam int BY_W    = (BY_N > 1) ? $clog2(BY_N) : 1;
  localparam int BX_LAST = BX_N - 1;
  localparam int BY_LAST = BY_N - 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic [BY_W-1:0] by_q, by_d;
  logic [2:0]      row_q, row_d;
  logic            half_q, half_d;
  logic            inflight_q;
  logic            frame_done_q, frame_done_d;
  logic            start_acc;

  logic [31:0]     fifo_mem [4];
  logic [1:0]      wr_ptr_q, rd_ptr_q;
  logic [2:0]      count_q;

  logic            push, pop, room, last_read;

  assign push      = inflight_q;
  assign cur_valid = (count_q != 3'd0);
  assign pop       = need_cur && cur_valid;
  assign cur_word  = cur_valid ? fifo_mem[rd_ptr_q] : 32'd0;
  assign busy      = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

  // Occupancy plus the one possible in-flight read must leave a slot for the new read.
  assign room   = ({1'b0, count_q} + {3'b000, inflight_q} + 4'd1) <= 4'd4;
  assign mem_rd = (state_q == S_FETCH) && room;

  assign last_read = half_q && (row_q == 3'd7) &&
                     (bx_q == BX_W'(BX_LAST)) && (by_q == BY_W'(BY_LAST));

  assign mem_addr = (addr_t'(by_q) * addr_t'(8) + addr_t'(row_q)) * addr_t'(FRAME_W / 4)
                  + addr_t'(bx_q) * addr_t'(2) + addr_t'(half_q);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    row_d        = row_q;
    half_d       = half_q;
    frame_done_d = 1'b0;
    start_acc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          start_acc = 1'b1;
        end
      end
      S_FETCH: begin
        if (mem_rd) begin
          half_d = ~half_q;
          if (half_q) begin
            row_d = row_q + 3'd1;
            if (row_q == 3'd7) begin
              if (bx_q == BX_W'(BX_LAST)) begin
                bx_d = '0;
                by_d = (by_q == BY_W'(BY_LAST)) ? '0 : by_q + BY_W'(1);
              end else begin
                bx_d = bx_q + BX_W'(1);
              end
            end
          end
          if (last_read) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (count_q == 3'd1) && !inflight_q) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bx_q         <= '0;
      by_q         <= '0;
      row_q        <= '0;
      half_q       <= 1'b0;
      inflight_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      row_q        <= row_d;
      half_q       <= half_d;
      inflight_q   <= mem_rd;
      frame_done_q <= frame_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; cur_word is masked while empty, so stale contents
  // are never observable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

`ifdef CUR_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (busy && need_cur && !cur_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cur_fetch.sv
// Self-checking bench for cur_fetch on a 16x8 frame: address order, data order, flow control,
// reset abort and ignored restarts, using an address/data scoreboard.
module tb_cur_fetch;

  localparam int FW      = 16;
  localparam int FH      = 8;
  localparam int AW      = 16;
  localparam int TOTAL   = FW * FH / 4;
  localparam int MAX_CYC = 400;

  logic          clk, rst, start, need_cur;
  logic [31:0]   cur_word, mem_rdata;
  logic          cur_valid, mem_rd, busy, frame_done;
  logic [AW-1:0] mem_addr;
`ifdef CUR_FETCH_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  cur_fetch #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .need_cur   (need_cur),
    .cur_word   (cur_word),
    .cur_valid  (cur_valid),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef CUR_FETCH_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // One-cycle read latency memory; returns junk when not read.
  always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic run_frame(input int need_mode, input int extra_start,
                           output int n_words, output int n_done,
                           output int first_valid, output int n_withheld);
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [15:0] a;
    logic [31:0] d;
    int issued, consumed, last_cons, done_cyc, gaps, outstanding;
    bit finished;
    for (int by = 0; by < FH / 8; by++)
      for (int bx = 0; bx < FW / 8; bx++)
        for (int row = 0; row < 8; row++)
          for (int half = 0; half < 2; half++)
            exp_addr.push_back(16'((by * 8 + row) * (FW / 4) + bx * 2 + half));
    issued = 0; consumed = 0; last_cons = -1; done_cyc = -1; gaps = 0;
    n_done = 0; first_valid = -1; n_withheld = 0; finished = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    need_cur = 1'b1;
    for (int cyc = 0; cyc < MAX_CYC && !finished; cyc++) begin
      @(negedge clk);
      outstanding = issued - consumed;
      if (busy && issued < TOTAL) begin
        checks++;
        if (mem_rd !== (outstanding < 4)) begin
          failures++;
          $display("FAIL read_issue cyc=%0d mem_rd=%b outstanding=%0d expected=%b",
                   cyc, mem_rd, outstanding, outstanding < 4);
        end
        if (!mem_rd) n_withheld++;
      end else if (mem_rd) begin
        checks++;
        failures++;
        $display("FAIL extra_read cyc=%0d mem_addr=%0d issued=%0d expected no read", cyc, mem_addr, issued);
      end
      if (mem_rd) begin
        issued++;
        if (exp_addr.size() != 0) begin
          a = exp_addr.pop_front();
          exp_data.push_back(mem_word(a));
          checks++;
          if (mem_addr !== a) begin
            failures++;
            $display("FAIL mem_addr cyc=%0d got=%0d expected=%0d", cyc, mem_addr, a);
          end
        end
      end
      if (cur_valid && first_valid < 0) first_valid = cyc;
      if (cur_valid && need_cur) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL extra_word cyc=%0d got=%h expected none", cyc, cur_word);
        end else begin
          d = exp_data.pop_front();
          if (cur_word !== d) begin
            failures++;
            $display("FAIL cur_word cyc=%0d got=%h expected=%h", cyc, cur_word, d);
          end
        end
        consumed++;
        last_cons = cyc;
      end else if (!cur_valid) begin
        checks++;
        if (cur_word !== 32'd0) begin
          failures++;
          $display("FAIL empty_word cyc=%0d got=%h expected=0", cyc, cur_word);
        end
      end
      if (need_mode == 0 && first_valid >= 0 && !cur_valid && consumed < TOTAL) gaps++;
      if (frame_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (consumed >= TOTAL && cyc >= last_cons + 2) begin
        finished = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = (cyc + 1 == extra_start);
        need_cur = (need_mode == 0) || ((cyc + 1) % 4 == 0);
      end
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL frame_timeout consumed=%0d expected=%0d", consumed, TOTAL);
    end
    if (need_mode == 0) begin
      checks++;
      if (gaps != 0) begin
        failures++;
        $display("FAIL stream_gaps got=%0d expected=0", gaps);
      end
    end
    checks++;
    if (done_cyc != last_cons + 1) begin
      failures++;
      $display("FAIL done_timing got=%0d expected=%0d", done_cyc, last_cons + 1);
    end
    checks++;
    if (exp_addr.size() != 0) begin
      failures++;
      $display("FAIL reads_missing got=%0d expected=0", exp_addr.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after got=%b expected=0", busy);
    end
    n_words = consumed;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; need_cur = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (cur_word !== 32'd0)  begin failures++; $display("FAIL rst_cur_word got=%h expected=0", cur_word); end
    if (cur_valid !== 1'b0)  begin failures++; $display("FAIL rst_cur_valid got=%b expected=0", cur_valid); end
    if (mem_rd !== 1'b0)     begin failures++; $display("FAIL rst_mem_rd got=%b expected=0", mem_rd); end
    if (mem_addr !== '0)     begin failures++; $display("FAIL rst_mem_addr got=%0d expected=0", mem_addr); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b expected=0", busy); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b expected=0", frame_done); end
    rst = 1'b0;
    need_cur = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold busy=%b mem_rd=%b expected 0/0", busy, mem_rd);
    end
  endtask

  task automatic check_frame(input string tag, input int nw, input int nd, input int fv,
                             input int exp_fv);
    checks++;
    if (nw != TOTAL) begin failures++; $display("FAIL %s_words got=%0d expected=%0d", tag, nw, TOTAL); end
    checks++;
    if (nd != 1) begin failures++; $display("FAIL %s_done_count got=%0d expected=1", tag, nd); end
    if (exp_fv >= 0) begin
      checks++;
      if (fv != exp_fv) begin failures++; $display("FAIL %s_first_valid got=%0d expected=%0d", tag, fv, exp_fv); end
    end
  endtask

  task automatic test_stream();
    int nw, nd, fv, nwh;
    run_frame(0, -1, nw, nd, fv, nwh);
    check_frame("stream", nw, nd, fv, 3);
    checks++;
    if (nwh != 0) begin failures++; $display("FAIL stream_withheld got=%0d expected=0", nwh); end
`ifdef CUR_FETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd2) begin failures++; $display("FAIL stall_cnt got=%0d expected=2", stall_cnt); end
`endif
  endtask

  task automatic test_throttle();
    int nw, nd, fv, nwh;
    run_frame(1, -1, nw, nd, fv, nwh);
    check_frame("throttle", nw, nd, fv, -1);
    checks++;
    if (nwh == 0) begin failures++; $display("FAIL throttle_full got=%0d withheld cycles expected >0", nwh); end
  endtask

  task automatic test_reset_mid();
    int consumed, nw, nd, fv, nwh;
    consumed = 0;
    @(posedge clk); #1;
    start = 1'b1; need_cur = 1'b1;
    for (int cyc = 0; cyc < MAX_CYC && consumed < 10; cyc++) begin
      @(negedge clk);
      if (cur_valid && need_cur) consumed++;
      if (consumed < 10) begin @(posedge clk); #1; start = 1'b0; end
    end
    start = 1'b0;
    checks++;
    if (consumed != 10 || mem_rd !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup consumed=%0d mem_rd=%b expected 10/1", consumed, mem_rd);
    end
    // Read issued this cycle returns while reset is being released.
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks++;
    if (cur_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || cur_word !== 32'd0) begin
      failures++;
      $display("FAIL mid_rst valid=%b busy=%b mem_rd=%b word=%h expected 0", cur_valid, busy, mem_rd, cur_word);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cur_valid !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL mid_discard valid=%b busy=%b mem_rd=%b expected 0/0/0", cur_valid, busy, mem_rd);
    end
    run_frame(0, -1, nw, nd, fv, nwh);
    check_frame("restart", nw, nd, fv, 3);
  endtask

  task automatic test_start_ignored();
    int nw, nd, fv, nwh;
    run_frame(0, 10, nw, nd, fv, nwh);
    check_frame("restart_ignored", nw, nd, fv, 3);
  endtask

  task automatic test_back_to_back();
    int nw, nd, fv, nwh;
    run_frame(1, 20, nw, nd, fv, nwh);
    check_frame("b2b_a", nw, nd, fv, -1);
    run_frame(0, -1, nw, nd, fv, nwh);
    check_frame("b2b_b", nw, nd, fv, 3);
`ifdef CUR_FETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd2) begin failures++; $display("FAIL b2b_stall_cnt got=%0d expected=2", stall_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_throttle();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
